quad_serial_subtractor: RTL and testbench
=========================================

Name: quad_serial_subtractor

Overview:
Digit-serial unsigned subtractor that computes result = dA - dB over WIDTH bits, 4 bits per clock.
- Companion to the quad serial adder; shares the same start/done operand handshake.
- Mirrors the adder's datapath, with borrow propagation in place of carry.
- Lets a controller issue a subtract in the same way as an add, without a full-width subtractor.

Parameters:
- WIDTH, 64, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per clock cycle.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- dA  input  WIDTH  minuend; captured on the accepting edge.
- dB  input  WIDTH  subtrahend; captured on the accepting edge.
- result  output  WIDTH  registered difference (dA - dB) mod 2^WIDTH.
- done  output  1  one-cycle pulse marking result and borrowOut valid.
- borrowOut  output  1  final borrow; 1 when dA < dB, unsigned.

Behaviour:
Reset:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- While rst is high: state = IDLE; result = 0, done = 0, borrowOut = 0; internal A/B shift registers, borrow flop and digit counter all cleared.
- rst asserted mid-operation aborts immediately; no partial result is exposed.

State machine: IDLE, BUSY, DONE. N = WIDTH/DIGIT (16 by default).
- IDLE:
  - done = 0; result and borrowOut hold their last values.
  - start = 1 at an edge: load A = dA, B = dB; borrow = 0; cnt = 0; go to BUSY.
- BUSY: on each edge:
  - d = A[DIGIT-1:0] - B[DIGIT-1:0] - borrow, computed at DIGIT+1 bits.
  - The low DIGIT bits of d shift into the result shift register from the MSB side.
  - borrow = d[DIGIT].
  - A and B shift right by DIGIT; cnt++.
  - When cnt == N-1 on this edge: go to DONE, copy the assembled difference to result, and copy the borrow to borrowOut.
- DONE: done = 1 for exactly one cycle; next edge returns to IDLE unconditionally. start is ignored in DONE.

Timing:
- Latency: accepting edge E; done high in the cycle following edge E+N (16 by default).
- Minimum issue interval: N+2 cycles.
- result and borrowOut stay stable from the done cycle until the next operation's completion edge.
- They do not change while BUSY; the shift register is internal.

Boundary conditions:
- start held high continuously → an operation is accepted on each IDLE visit, giving one idle cycle between operations.
- dA/dB changing during BUSY → no effect; only captured operands are used.
- dA == dB → result 0, borrowOut 0.
- dA < dB → wrapped two's-complement difference, borrowOut 1.
- rst and start both high → reset wins.

Optional Feature:
Macro QSS_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit), reset value 0.
  - Updated with result on the completion edge: overflow = (A_msb != B_msb) && (R_msb != A_msb), with operands read as signed two's complement.
  - Requires a registered copy of the captured operand MSBs.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. dA=0x10, dB=0x01, start one cycle → done pulses exactly 17 cycles after the accepting edge; result=0x000000000000000F; borrowOut=0.
2. dA=0, dB=1 → result=0xFFFFFFFFFFFFFFFF, borrowOut=1, done a single-cycle pulse.
3. dA=dB=0x123456789ABCDEF0 → result=0, borrowOut=0.
4. start held high; dA changed to 0xFFFF... during BUSY:
   - Completes with the captured operands.
   - Exactly one IDLE cycle, then a new operation is accepted.
   - result stable between done pulses.
5. rst pulsed during BUSY cycle 8 → result/done/borrowOut read 0 immediately (asynchronous). A following op with dA=100, dB=58 gives result=42, borrowOut=0.
6. With QSS_OVERFLOW_EN:
   - dA=0x8000000000000000, dB=1 → result=0x7FFFFFFFFFFFFFFF, overflow=1.
   - dA=5, dB=3 → overflow=0.

Source files
------------

// File: rtl/quad_serial_subtractor.sv
// quad_serial_subtractor: digit-serial unsigned subtractor, result = dA - dB
// computed DIGIT bits per clock, least-significant digit first, with the
// borrow carried between digits in a single flop.
// Optional build macro QSS_OVERFLOW_EN adds a signed-overflow output.
module quad_serial_subtractor #(
   parameter int WIDTH = 64,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dA,
   input  logic [WIDTH-1:0] dB,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             borrowOut
`ifdef QSS_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int RW = WIDTH - DIGIT;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   // Holds the digits produced so far; the final digit joins them directly
   // on the completion edge, so only WIDTH-DIGIT bits need storing.
   logic [RW-1:0]   r_sh;
   logic            borrow;
   logic [CW-1:0]   cnt;
   logic [DIGIT:0]  diff;
   logic            last;
`ifdef QSS_OVERFLOW_EN
   logic            a_msb;
   logic            b_msb;
`endif

   // One digit of difference with borrow-in; bit DIGIT is the borrow-out.
   always_comb begin
      diff = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};
   end

   assign last = (cnt == CW'(N - 1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: start only matters in IDLE, DONE always returns to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = BUSY;
         BUSY:    if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, digit shifting and publication of the finished result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh      <= '0;
         b_sh      <= '0;
         r_sh      <= '0;
         borrow    <= 1'b0;
         cnt       <= '0;
         result    <= '0;
         done      <= 1'b0;
         borrowOut <= 1'b0;
`ifdef QSS_OVERFLOW_EN
         a_msb     <= 1'b0;
         b_msb     <= 1'b0;
         overflow  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh   <= dA;
                  b_sh   <= dB;
                  borrow <= 1'b0;
                  cnt    <= '0;
`ifdef QSS_OVERFLOW_EN
                  a_msb  <= dA[WIDTH-1];
                  b_msb  <= dB[WIDTH-1];
`endif
               end
            end
            BUSY: begin
               r_sh   <= {diff[DIGIT-1:0], r_sh[RW-1:DIGIT]};
               borrow <= diff[DIGIT];
               a_sh   <= a_sh >> DIGIT;
               b_sh   <= b_sh >> DIGIT;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  result    <= {diff[DIGIT-1:0], r_sh};
                  borrowOut <= diff[DIGIT];
                  done      <= 1'b1;
`ifdef QSS_OVERFLOW_EN
                  // Signed overflow: operands of opposite sign and the
                  // difference's sign disagrees with the minuend's.
                  overflow  <= (a_msb != b_msb) && (diff[DIGIT-1] != a_msb);
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_quad_serial_subtractor.sv
// Self-checking bench for quad_serial_subtractor (default WIDTH=64, DIGIT=4).
// Expected results are computed from the operands when an operation is
// issued, queued, and compared when done is observed.
module tb_quad_serial_subtractor;

   localparam int W = 64;
   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dA;
   logic [W-1:0] dB;
   logic [W-1:0] result;
   logic         done;
   logic         borrowOut;
`ifdef QSS_OVERFLOW_EN
   logic         overflow;
`endif

   typedef struct {
      logic [W-1:0] res;
      logic         bout;
      logic         ovf;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   quad_serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .dA(dA),
      .dB(dB),
      .result(result),
      .done(done),
      .borrowOut(borrowOut)
`ifdef QSS_OVERFLOW_EN
      ,
      .overflow(overflow)
`endif
   );

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.res  = a - b;
      e.bout = (a < b);
      e.ovf  = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      return e;
   endfunction

   // Count posedges until done is seen high (sampled 1 time unit after the edge).
   task automatic wait_done(output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Issue one operation from IDLE, wait for completion, pop its expectation,
   // then step over the DONE->IDLE edge and report done there.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output bit ok, output exp_t e,
                         output logic done_after);
      @(negedge clk);
      dA = a; dB = b; start = 1'b1;
      q.push_back(model(a, b));
      @(posedge clk); #1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, ok);
      lat = lat + 1;
      e = q.pop_front();
      @(posedge clk); #1;
      done_after = done;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; dA = 64'h5; dB = 64'h1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (result !== '0)   $display("FAIL reset_result got %h want 0", result); else passed++;
      total++; if (done !== 1'b0)   $display("FAIL reset_done got %b want 0", done); else passed++;
      total++; if (borrowOut !== 1'b0) $display("FAIL reset_borrow got %b want 0", borrowOut); else passed++;
`ifdef QSS_OVERFLOW_EN
      total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else passed++;
`endif
      @(negedge clk);
      start = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      int lat; bit ok; exp_t e; logic da;
      run_op(64'h10, 64'h01, lat, ok, e, da);
      total++; if (!ok) $display("FAIL basic_timeout no done"); else passed++;
      // lat counts posedges from the accepting edge through the edge after
      // which done is sampled: N busy edges plus one.
      total++; if (lat != N + 1) $display("FAIL basic_latency got %0d want %0d", lat, N + 1); else passed++;
      total++; if (result !== 64'h000000000000000F) $display("FAIL basic_result got %h want %h", result, 64'hF); else passed++;
      total++; if (result !== e.res) $display("FAIL basic_model got %h want %h", result, e.res); else passed++;
      total++; if (borrowOut !== 1'b0) $display("FAIL basic_borrow got %b want 0", borrowOut); else passed++;
      total++; if (da !== 1'b0) $display("FAIL basic_pulse done after got %b want 0", da); else passed++;
   endtask

   task automatic test_wrap;
      int lat; bit ok; exp_t e; logic da;
      run_op(64'h0, 64'h1, lat, ok, e, da);
      total++; if (!ok) $display("FAIL wrap_timeout no done"); else passed++;
      total++; if (result !== 64'hFFFFFFFFFFFFFFFF) $display("FAIL wrap_result got %h want all ones", result); else passed++;
      total++; if (borrowOut !== 1'b1) $display("FAIL wrap_borrow got %b want 1", borrowOut); else passed++;
      total++; if (da !== 1'b0) $display("FAIL wrap_pulse done after got %b want 0", da); else passed++;
   endtask

   task automatic test_equal;
      int lat; bit ok; exp_t e; logic da;
      run_op(64'h123456789ABCDEF0, 64'h123456789ABCDEF0, lat, ok, e, da);
      total++; if (!ok) $display("FAIL equal_timeout no done"); else passed++;
      total++; if (result !== '0) $display("FAIL equal_result got %h want 0", result); else passed++;
      total++; if (borrowOut !== e.bout) $display("FAIL equal_borrow got %b want %b", borrowOut, e.bout); else passed++;
   endtask

   task automatic test_back_to_back;
      int lat; bit ok; exp_t e1; exp_t e2; int gap; bit stable;
      logic [W-1:0] r1; logic b1;
      @(negedge clk);
      start = 1'b1; dA = 64'h1111000000000005; dB = 64'h3;
      q.push_back(model(64'h1111000000000005, 64'h3));
      @(posedge clk); #1;
      // Change the minuend during BUSY; the second op captures this value.
      @(negedge clk);
      dA = 64'hFFFFFFFFFFFFFFFF;
      q.push_back(model(64'hFFFFFFFFFFFFFFFF, 64'h3));
      wait_done(lat, ok);
      e1 = q.pop_front();
      total++; if (!ok) $display("FAIL b2b_timeout1 no done"); else passed++;
      total++; if (result !== e1.res) $display("FAIL b2b_result1 got %h want %h", result, e1.res); else passed++;
      total++; if (borrowOut !== e1.bout) $display("FAIL b2b_borrow1 got %b want %b", borrowOut, e1.bout); else passed++;
      r1 = result; b1 = borrowOut;
      gap = 0; stable = 1'b1; ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         gap++;
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         if (result !== r1 || borrowOut !== b1) stable = 1'b0;
      end
      @(negedge clk);
      start = 1'b0;
      e2 = q.pop_front();
      total++; if (!ok) $display("FAIL b2b_timeout2 no done"); else passed++;
      total++; if (gap != N + 2) $display("FAIL b2b_interval got %0d want %0d", gap, N + 2); else passed++;
      total++; if (!stable) $display("FAIL b2b_stable got changed want held %h", r1); else passed++;
      total++; if (result !== e2.res) $display("FAIL b2b_result2 got %h want %h", result, e2.res); else passed++;
      total++; if (borrowOut !== e2.bout) $display("FAIL b2b_borrow2 got %b want %b", borrowOut, e2.bout); else passed++;
      @(posedge clk); #1;
      total++; if (done !== 1'b0) $display("FAIL b2b_pulse done after got %b want 0", done); else passed++;
   endtask

   task automatic test_mid_reset;
      int lat; bit ok; exp_t e; logic da;
      @(negedge clk);
      start = 1'b1; dA = 64'hDEAD; dB = 64'hBEEF;
      q.push_back(model(64'hDEAD, 64'hBEEF));
      @(posedge clk); #1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      total++; if (result !== '0) $display("FAIL midrst_result got %h want 0", result); else passed++;
      total++; if (done !== 1'b0) $display("FAIL midrst_done got %b want 0", done); else passed++;
      total++; if (borrowOut !== 1'b0) $display("FAIL midrst_borrow got %b want 0", borrowOut); else passed++;
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(64'd100, 64'd58, lat, ok, e, da);
      total++; if (!ok) $display("FAIL after_rst_timeout no done"); else passed++;
      total++; if (result !== 64'd42) $display("FAIL after_rst_result got %0d want 42", result); else passed++;
      total++; if (borrowOut !== 1'b0) $display("FAIL after_rst_borrow got %b want 0", borrowOut); else passed++;
   endtask

`ifdef QSS_OVERFLOW_EN
   task automatic test_overflow;
      int lat; bit ok; exp_t e; logic da;
      run_op(64'h8000000000000000, 64'h1, lat, ok, e, da);
      total++; if (result !== 64'h7FFFFFFFFFFFFFFF) $display("FAIL ovf_result got %h want 7fffffffffffffff", result); else passed++;
      total++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow); else passed++;
      run_op(64'd5, 64'd3, lat, ok, e, da);
      total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else passed++;
      total++; if (result !== 64'd2) $display("FAIL ovf_small_result got %0d want 2", result); else passed++;
   endtask
`endif

   initial begin
      rst = 1'b1; start = 1'b0; dA = '0; dB = '0;
      test_reset();
      test_basic();
      test_wrap();
      test_equal();
      test_back_to_back();
      test_mid_reset();
`ifdef QSS_OVERFLOW_EN
      test_overflow();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
